// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline stage registers
//               and the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Occupancy of a two-entry skid stage
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Width of the optional back-pressure statistics counter
  localparam int STALL_CNT_W = 32;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_data_reg.sv
// ============================================================================
// Module      : pipe_data_reg
// Description : W-bit data register with load enable and synchronous,
//               active-high reset to RESET_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_data_reg #(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Load new data only when enabled, otherwise hold
  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  // Storage flop with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) data_q <= RESET_VAL;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule : pipe_data_reg

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module      : pipe_skid_stage
// Description : Two-entry skid-buffer pipeline stage with valid/ready
//               handshake, synchronous flush and full-throughput
//               back-pressure. in_ready/out_valid come from registered state
//               only, so there is no combinational ready path through it.
//               Optional feature macro: PIPE_SKID_STATS_EN adds the stall_cnt
//               port counting cycles with out_valid=1 and out_ready=0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_t  state_d, state_q;
  logic         in_fire, out_fire;
  logic         main_en, skid_en;
  logic [W-1:0] main_in, skid_q;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL) & ~rst;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next state and data-register load enables; flush clears occupancy only
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_in = in_data;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_en = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          state_d = FULL;
          skid_en = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        main_in = skid_q;
        if (out_fire) begin
          state_d = ONE;
          main_en = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops every held or arriving beat; the data registers keep
    // their stale contents since nothing reads them while EMPTY
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Head entry: drives out_data
  pipe_data_reg #(
    .W         (W),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_in),
    .q   (out_data)
  );

  // Second entry: catches the beat accepted while the head is stalled
  pipe_data_reg #(
    .W         (W),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

`ifdef PIPE_SKID_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // Saturating count of stalled-output cycles; flush does not clear it
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Statistics counter register
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : pipe_skid_stage

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Self-checking bench for pipe_skid_stage: table of directed
//               vectors plus hand-written multi-cycle sequences.
//               Honours PIPE_SKID_STATS_EN for the stall counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .W         (32),
    .RESET_VAL (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Inputs applied for one cycle and the outputs required just before
  // that cycle's rising edge
  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [31:0] od;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [44:0] rdy_pat;
    logic [31:0] nxt;
    logic        e_ir, e_ov, ordy, iv;

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    //           rst   flush iv    d             ordy  ov    ir    od
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    // streaming
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'd1,        1'b1, 1'b0, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'd2,        1'b1, 1'b1, 1'b1, 32'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'd3,        1'b1, 1'b1, 1'b1, 32'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'd4,        1'b1, 1'b1, 1'b1, 32'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'd4};
    // back-pressure
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'd5,        1'b0, 1'b0, 1'b1, 32'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'd6,        1'b0, 1'b1, 1'b1, 32'd5};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'd99,       1'b0, 1'b1, 1'b0, 32'd5};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'd5};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'd6};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'd6};
    // flush while FULL, then flush with an accepted beat
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'hA,        1'b0, 1'b0, 1'b1, 32'd6};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'hB,        1'b0, 1'b1, 1'b1, 32'hA};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 32'd7,        1'b0, 1'b1, 1'b0, 32'hA};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 32'd7,        1'b0, 1'b0, 1'b1, 32'hA};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA};
    // simultaneous fire in ONE
    vecs[21] = '{1'b0, 1'b0, 1'b1, 32'd8,        1'b1, 1'b0, 1'b1, 32'hA};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 32'd9,        1'b1, 1'b1, 1'b1, 32'd8};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'd9};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'd9};
    // reset mid-operation
    vecs[25] = '{1'b1, 1'b0, 1'b1, 32'hC,        1'b0, 1'b1, 1'b0, 32'd9};
    vecs[26] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ov});
      check($sformatf("vec%0d in_ready",  i), {31'b0, in_ready},  {31'b0, vecs[i].ir});
      check($sformatf("vec%0d out_data",  i), out_data, vecs[i].od);
      step();
    end

`ifdef PIPE_SKID_STATS_EN
    // stage is EMPTY with the counter freshly cleared by vec25
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("stall after rst", stall_cnt, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 10; k++) step();
    #1 check("stall 10 cycles", stall_cnt, 32'd10);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("stall after flush", stall_cnt, 32'd10);
    check("ov after flush", {31'b0, out_valid}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("stall after rst2", stall_cnt, 32'd0);
    step();
`endif

    // FIFO-ordering sequence: upstream always offers a beat, downstream
    // ready follows a fixed pattern, then drains; a queue holds the
    // beats the stage should contain
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    rdy_pat = 45'b11111_1011_0010_0111_0001_1100_1010_0110_1111_0000_1101;
    nxt = 32'h100;
    for (int c = 0; c < 45; c++) begin
      iv   = (c < 40);
      ordy = rdy_pat[c];
      drive(1'b0, 1'b0, iv, nxt, ordy);
      #1;
      e_ov = (q.size() > 0);
      e_ir = (q.size() < 2);
      check($sformatf("seq%0d out_valid", c), {31'b0, out_valid}, {31'b0, e_ov});
      check($sformatf("seq%0d in_ready",  c), {31'b0, in_ready},  {31'b0, e_ir});
      if (e_ov) check($sformatf("seq%0d out_data", c), out_data, q[0]);
      if (e_ov && ordy) void'(q.pop_front());
      if (iv && e_ir) begin
        q.push_back(nxt);
        nxt = nxt + 32'd1;
      end
      step();
    end
    #1 check("seq drained", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_skid_stage

`default_nettype wire
